// File: rtl/core_max_pooling_ctrl_pkg.sv
// Shared definitions for the max-pooling sequencer: FSM encoding and map geometry helpers.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package core_max_pooling_ctrl_pkg;

  // Layer sequencing states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Pixels consumed per channel
  function automatic int pix_per_ch(input int w, input int h);
    return w * h;
  endfunction

  // 2x2 pooled words produced per channel
  function automatic int outs_per_ch(input int w, input int h);
    return (w / 2) * (h / 2);
  endfunction

  // Counter width able to hold the full pixel count of one channel
  function automatic int cnt_width(input int w, input int h);
    return $clog2(w * h + 1);
  endfunction

  localparam int DEF_WIDTH  = 56;
  localparam int DEF_HEIGHT = 56;
  localparam int DEF_PIX    = pix_per_ch(DEF_WIDTH, DEF_HEIGHT);
  localparam int DEF_OUTS   = outs_per_ch(DEF_WIDTH, DEF_HEIGHT);
  localparam int DEF_CNT_W  = cnt_width(DEF_WIDTH, DEF_HEIGHT);

endpackage

// File: rtl/core_max_pooling_ctrl_skid_fifo.sv
// Generic synchronous FIFO used as the pooling-output skid buffer (DEPTH x DW).
// Latency: write visible at head one cycle later; head is read combinationally.
// Backpressure: writes while full are discarded, reads while empty are ignored.
module maxpool_skid_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [DW-1:0]              wr_data,
  input  logic                       rd_en,
  output logic [DW-1:0]              rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_fire;
  logic          rd_fire;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + AW'(1);
      if (rd_fire) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_fire, rd_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset because the head is masked while empty
  always_ff @(posedge clock) begin
    if (wr_fire) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/core_max_pooling_ctrl.sv
// Max-pooling layer sequencer: input FIFO -> pooling core -> skid buffer -> output FIFO, per channel.
// Latency: ff_rdreq is combinational; pool_valid_in follows it by one cycle; ff_wrreq is combinational on skid state.
// Backpressure: ff_full stalls the skid drain; reads stop once skid entries plus in-flight reads reach SKID_DEPTH.
// Optional build macro MAXPOOL_CTRL_STALL_CNT_EN adds the stall_cycles output.
module core_max_pooling_ctrl
  import core_max_pooling_ctrl_pkg::*;
#(
  parameter int DWIDTH     = 32,
  parameter int WIDTH      = 56,
  parameter int HEIGHT     = 56,
  parameter int POOL_LAT   = 4,
  parameter int SKID_DEPTH = 8,
  parameter int CH_W       = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [CH_W-1:0]   cfg_channels,
  output logic              busy,
  output logic              done,
  output logic              err_overflow,
  input  logic [DWIDTH-1:0] ff_rdata,
  output logic              ff_rdreq,
  input  logic              ff_empty,
  output logic [DWIDTH-1:0] ff_wdata,
  output logic              ff_wrreq,
  input  logic              ff_full,
  output logic [DWIDTH-1:0] pool_data_in,
  output logic              pool_valid_in,
  output logic              pool_clear,
`ifdef MAXPOOL_CTRL_STALL_CNT_EN
  output logic [31:0]       stall_cycles,
`endif
  input  logic [DWIDTH-1:0] pool_data_out,
  input  logic              pool_valid_out
);

  localparam int PIX    = pix_per_ch(WIDTH, HEIGHT);
  localparam int OUTS   = outs_per_ch(WIDTH, HEIGHT);
  localparam int CNT_W  = cnt_width(WIDTH, HEIGHT);
  localparam int SK_CW  = $clog2(SKID_DEPTH + 1);
  localparam int SR_LEN = POOL_LAT + 1;
  localparam int INF_W  = $clog2(SR_LEN + 1);
  localparam int OCC_W  = $clog2(SKID_DEPTH + SR_LEN + 1);

  localparam logic [CNT_W-1:0] PIX_C  = CNT_W'(PIX);
  localparam logic [CNT_W-1:0] OUTS_C = CNT_W'(OUTS);

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  in_cnt;
  logic [CNT_W-1:0]  out_cnt;
  logic [CH_W-1:0]   ch_cnt;
  logic [CH_W-1:0]   channels;
  logic              start_acc;
  logic              last_ch;
  logic              chan_done;
  logic [SR_LEN-1:0] rd_hist;
  logic [INF_W-1:0]  inflight;
  logic [OCC_W-1:0]  occupancy;
  logic              rd_ok;

  logic [DWIDTH-1:0] skid_head;
  logic [SK_CW-1:0]  skid_cnt;
  logic              skid_full;
  logic              skid_empty;

  assign start_acc = (state == ST_IDLE) && start;
  assign last_ch   = (({1'b0, ch_cnt} + (CH_W+1)'(1)) >= {1'b0, channels});
  // A channel is finished only once every pooled word has left the skid buffer
  assign chan_done = (out_cnt == OUTS_C) && skid_empty;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; start is only honoured from IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = (cfg_channels != '0) ? ST_CLEAR : ST_DONE;
      end
      ST_CLEAR: state_nxt = ST_RUN;
      ST_RUN: begin
        if (in_cnt == PIX_C) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (chan_done) state_nxt = last_ch ? ST_DONE : ST_CLEAR;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded outputs, including the gated input FIFO read request
  always_comb begin
    busy       = (state != ST_IDLE);
    done       = (state == ST_DONE);
    pool_clear = (state == ST_CLEAR);
    ff_rdreq   = (state == ST_RUN) && !ff_empty && (in_cnt < PIX_C) && rd_ok;
  end

  // Count reads still able to produce a pooled word; each reserves one skid slot
  always_comb begin
    inflight = '0;
    for (int i = 0; i < SR_LEN; i++) begin
      inflight = inflight + INF_W'(rd_hist[i]);
    end
  end

  assign occupancy = OCC_W'(skid_cnt) + OCC_W'(inflight);
  assign rd_ok     = (occupancy < OCC_W'(SKID_DEPTH));

  // Read history window and the pixel strobe that trails each read by one cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_hist       <= '0;
      pool_valid_in <= 1'b0;
    end else begin
      rd_hist       <= {rd_hist[SR_LEN-2:0], ff_rdreq};
      pool_valid_in <= ff_rdreq;
    end
  end

  // FIFO read data arrives the cycle after rdreq and is forwarded only alongside its strobe
  assign pool_data_in = pool_valid_in ? ff_rdata : '0;

  // Channel configuration capture and channel progress
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      channels <= '0;
      ch_cnt   <= '0;
    end else if (start_acc) begin
      channels <= cfg_channels;
      ch_cnt   <= '0;
    end else if ((state == ST_DRAIN) && chan_done) begin
      ch_cnt   <= ch_cnt + CH_W'(1);
    end
  end

  // Per-channel pixel and output counters, rewound on every CLEAR
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in_cnt  <= '0;
      out_cnt <= '0;
    end else if (state == ST_CLEAR) begin
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      if (ff_rdreq) in_cnt  <= in_cnt + CNT_W'(1);
      if (ff_wrreq) out_cnt <= out_cnt + CNT_W'(1);
    end
  end

  // Sticky overflow flag; an overflow in the start cycle still wins over the clear
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_overflow <= 1'b0;
    end else begin
      if (start_acc)                    err_overflow <= 1'b0;
      if (pool_valid_out && skid_full)  err_overflow <= 1'b1;
    end
  end

  maxpool_skid_fifo #(
    .DEPTH (SKID_DEPTH),
    .DW    (DWIDTH)
  ) u_skid (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (pool_valid_out),
    .wr_data (pool_data_out),
    .rd_en   (ff_wrreq),
    .rd_data (skid_head),
    .count   (skid_cnt),
    .full    (skid_full),
    .empty   (skid_empty)
  );

  assign ff_wrreq = !skid_empty && !ff_full;
  assign ff_wdata = skid_empty ? '0 : skid_head;

`ifdef MAXPOOL_CTRL_STALL_CNT_EN
  logic stall_now;
  assign stall_now = ((state == ST_RUN) || (state == ST_DRAIN)) && !skid_empty && !ff_wrreq;

  // Saturating count of cycles the output FIFO held back pending skid data
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else if (start_acc) begin
      stall_cycles <= '0;
    end else if (stall_now && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`else
  // Stall accounting is not built in this configuration.
`endif

endmodule
